// File: rtl/add_slice_sched.sv
// rtl/add_slice_sched.sv - round-robin sequencer for one shared SLICE_W-bit adder slice
// Each granted add runs N_SLICES passes LSB-first with the slice carry registered between passes.
module add_slice_sched #(
   parameter int SLICE_W  = 4,
   parameter int N_SLICES = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req0,
   input  logic [SLICE_W*N_SLICES-1:0] a0,
   input  logic [SLICE_W*N_SLICES-1:0] b0,
   input  logic                        cin0,
   input  logic                        req1,
   input  logic [SLICE_W*N_SLICES-1:0] a1,
   input  logic [SLICE_W*N_SLICES-1:0] b1,
   input  logic                        cin1,
   output logic                        gnt0,
   output logic                        gnt1,
   output logic [SLICE_W-1:0]          sl_a,
   output logic [SLICE_W-1:0]          sl_b,
   output logic                        sl_cin,
   input  logic [SLICE_W-1:0]          sl_s,
   input  logic                        sl_cout,
   output logic                        busy,
   output logic                        done,
   output logic                        done_id,
   output logic [SLICE_W*N_SLICES-1:0] sum,
   output logic                        cout
);

   localparam int W     = SLICE_W * N_SLICES;
   localparam int IDX_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [W-1:0]     a_lat;
   logic [W-1:0]     b_lat;
   logic             cin_lat;
   logic             id_lat;
   logic             last_id;
   logic [W-1:0]     sum_reg;
   logic             carry_reg;
   logic [W-1:0]     sum_next;
   int unsigned      base;

   // Grants are combinational and only offered in IDLE; a tie goes to whoever was not served last.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n && state == IDLE) begin
         gnt0 = req0 && (!req1 || last_id);
         gnt1 = req1 && (!req0 || !last_id);
      end
   end

   always_comb begin
      base     = int'(idx) * SLICE_W;
      sl_a     = '0;
      sl_b     = '0;
      sl_cin   = 1'b0;
      sum_next = sum_reg;
      if (state == RUN) begin
         sl_a   = a_lat[base +: SLICE_W];
         sl_b   = b_lat[base +: SLICE_W];
         sl_cin = (idx == '0) ? cin_lat : carry_reg;
      end
      sum_next[base +: SLICE_W] = sl_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         a_lat     <= '0;
         b_lat     <= '0;
         cin_lat   <= 1'b0;
         id_lat    <= 1'b0;
         last_id   <= 1'b1;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         done_id   <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  a_lat   <= gnt1 ? a1 : a0;
                  b_lat   <= gnt1 ? b1 : b0;
                  cin_lat <= gnt1 ? cin1 : cin0;
                  id_lat  <= gnt1;
                  last_id <= gnt1;
                  idx     <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               sum_reg   <= sum_next;
               carry_reg <= sl_cout;
               idx       <= idx + IDX_W'(1);
               // Result outputs are loaded only here so they hold steady across later operations.
               if (idx == LAST_IDX) begin
                  state   <= FIN;
                  done    <= 1'b1;
                  done_id <= id_lat;
                  sum     <= sum_next;
                  cout    <= sl_cout;
               end
            end
            FIN: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/add_slice_sched.md
Name: add_slice_sched

Overview:
- Sequencing controller and arbiter for one shared 4-bit ripple-carry adder slice.
- Accepts 16-bit add requests from two requesters and grants them round-robin.
- Runs each granted operation as four slice passes, least-significant slice first, through the external slice. The slice carry is registered between passes.
- Returns a 16-bit sum and carry-out with a done pulse. This trades latency for area against a full 16-bit ripple adder.

Parameters:
- SLICE_W, 4, width of the shared adder slice.
- N_SLICES, 4, number of passes per operation. Operand width is SLICE_W*N_SLICES = 16. Only the defaults are verified.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  requester 0 request (level; hold until gnt0)
- a0  input  16  requester 0 operand A
- b0  input  16  requester 0 operand B
- cin0  input  1  requester 0 carry-in
- req1  input  1  requester 1 request (level; hold until gnt1)
- a1  input  16  requester 1 operand A
- b1  input  16  requester 1 operand B
- cin1  input  1  requester 1 carry-in
- gnt0  output  1  requester 0 operands accepted this cycle
- gnt1  output  1  requester 1 operands accepted this cycle
- sl_a  output  4  slice operand A
- sl_b  output  4  slice operand B
- sl_cin  output  1  slice carry-in
- sl_s  input  4  slice sum (combinational from sl_a/sl_b/sl_cin)
- sl_cout  input  1  slice carry-out
- busy  output  1  operation in progress
- done  output  1  one-cycle result-valid pulse
- done_id  output  1  requester that owns the result
- sum  output  16  result sum
- cout  output  1  result carry-out

Behaviour:
- Reset (asynchronous, takes effect immediately, any state):
  - State goes to IDLE; all outputs are 0.
  - Internal operand/sum/carry registers are 0; last_id = 1, so requester 0 wins the first tie.
- States:
  - IDLE, RUN (pass index idx 0..3), DONE.
- IDLE:
  - gnt0/gnt1 are combinational in this state only, and at most one is high.
  - Only req0 -> gnt0. Only req1 -> gnt1. Both -> grant the requester != last_id.
  - On a grant edge: latch a/b/cin and the id; last_id <= id; idx <= 0; go to RUN.
  - No request -> stay in IDLE.
- RUN:
  - busy = 1.
  - sl_a = A_lat[4*idx+3:4*idx]; sl_b = B_lat[4*idx+3:4*idx].
  - sl_cin = cin_lat when idx == 0, otherwise carry_reg.
  - Each edge: sum_reg slice idx <= sl_s; carry_reg <= sl_cout; idx++.
  - At idx == 3, go to DONE.
- DONE (one cycle):
  - done = 1; busy = 1; done_id = latched id.
  - sum = sum_reg; cout = carry_reg.
  - Then go to IDLE; no grant is issued in DONE.
- Output holding:
  - sum/cout/done_id hold their values until the next DONE.
  - They do not update mid-operation.
  - sl_* = 0 outside RUN.
- Timing:
  - Grant in cycle T; passes in T+1..T+4; done in T+5.
  - Earliest next grant is T+6, i.e. one operation per 6 cycles.
- Requests:
  - Request changes or operand changes after the grant are ignored, since operands are latched.
  - A request withdrawn before its grant has no effect.
  - Requests raised during RUN/DONE wait for IDLE.
- Arithmetic: {cout,sum} = A + B + cin, modulo 2^17; there is no overflow flag.
- Reset mid-operation: the operation is aborted with no done pulse. The interrupted requester must re-request.

Test Plan:
- Reset: assert rst_n = 0 mid-clock -> all outputs 0 immediately, no clock edge needed; the first tie after release grants requester 0.
- Basic add, requester 0: req0 with a0 = 0x1234, b0 = 0x4321, cin0 = 0 -> gnt0 in cycle T; done at T+5 with sum = 0x5555, cout = 0, done_id = 0; busy high for T+1..T+5.
- Inter-slice carry:
  - a = 0xFFFF, b = 0x0001, cin = 0 -> sum = 0x0000, cout = 1.
  - a = 0x0FFF, b = 0x0000, cin = 1 -> sum = 0x1000, cout = 0.
- Arbitration: req0 and req1 both held continuously -> grant order gnt0, gnt1, gnt0 with grants 6 cycles apart; done_id alternates 0, 1, 0; gnt0 and gnt1 never high together.
- Abort: pulse rst_n low at idx = 2 -> busy = 0 at once, no done; req1 afterwards with 0x8000 + 0x8000 -> sum = 0x0000, cout = 1, done_id = 1.
- Random: 1000 operations with random operands and requesters, with the slice modelled as a 4-bit adder -> every {cout,sum} matches A + B + cin, and every requester is served in round-robin order.
